ps2_key_event_fifo: RTL and testbench

Downstream consumer of the PS/2 receiver's 16-bit held scan-code output.
- Detects each new code value and classifies it as make, break or extended.
- Buffers the events in a small first-word-fall-through FIFO.
- Presents the events to the system side on a valid/ready handshake, so no key event is lost when the consumer is slow.

---
 rtl/ps2_key_event_fifo.sv | 95 +++++++++
 tb/tb_ps2_key_event_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_fifo.sv
// Turns changes of the PS/2 held scan code into make/break/extended events and
// queues them in a first-word-fall-through FIFO. Macro PS2_BREAK_FILTER_EN drops break codes.
module ps2_key_event_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       code_in,
    input  logic              ev_ready,
    input  logic              clr_ovf,
    output logic              ev_valid,
    output logic [15:0]       ev_code,
    output logic              ev_break,
    output logic              ev_ext,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       code_prev;
    logic [17:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [17:0]       head;

    logic new_ev;
    logic is_brk;
    logic is_ext;
    logic push_req;
    logic pop;
    logic full;
    logic push;
    logic drop;

    always_comb begin
        new_ev = (code_in != code_prev) && (code_in != 16'h0000);
        is_brk = (code_in[15:8] == 8'hF0);
        is_ext = (code_in[15:8] == 8'hE0);
`ifdef PS2_BREAK_FILTER_EN
        push_req = new_ev && !is_brk;
`else
        push_req = new_ev;
`endif
        pop  = (count != '0) && ev_ready;
        full = (count == FULL_CNT);
        // A pop in the same edge frees the slot, so a full FIFO still accepts.
        push = push_req && (!full || pop);
        drop = push_req && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_prev <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            code_prev <= code_in;
            if (push) begin
                mem[wr_ptr] <= {is_ext, is_brk, code_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign ev_valid = (count != '0);
    assign ev_code  = head[15:0];
    assign ev_ext   = head[17];
`ifdef PS2_BREAK_FILTER_EN
    assign ev_break = 1'b0;
`else
    assign ev_break = head[16];
`endif

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench for ps2_key_event_fifo: stimulus queues expected events,
// a negedge monitor compares each handshaken head entry in order.
module tb_ps2_key_event_fifo;

`ifdef PS2_BREAK_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] code_in;
    logic        ev_ready;
    logic        clr_ovf;
    logic        ev_valid;
    logic [15:0] ev_code;
    logic        ev_break;
    logic        ev_ext;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    ps2_key_event_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .code_in  (code_in),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_break (ev_break),
        .ev_ext   (ev_ext),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply a new code and queue the event the FIFO is expected to keep.
    task automatic send(input logic [15:0] c, input bit accepted);
        logic brk;
        logic ext;
        brk = (c[15:8] == 8'hF0);
        ext = (c[15:8] == 8'hE0);
        code_in = c;
        if (accepted && !(FILTER && brk)) exp_q.push_back({ext, brk && !FILTER, c});
        tick();
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        for (int i = 0; i < 20 && count != 0; i++) tick();
        ev_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(ev_valid), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            logic [17:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", {ev_ext, ev_break, ev_code});
            end else begin
                e = exp_q.pop_front();
                if ({ev_ext, ev_break, ev_code} !== e) begin
                    errors++;
                    $display("FAIL pop_entry: got %0h expected %0h", {ev_ext, ev_break, ev_code}, e);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        code_in  = 16'h0000;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_code", 32'(ev_code), 0);
        rst_n = 1'b1;
        tick();

        // single held make code -> one event
        send(16'h001C, 1'b1);
        chk("t1_valid", 32'(ev_valid), 1);
        chk("t1_count", 32'(count), 1);
        chk("t1_code", 32'(ev_code), 32'h001C);
        chk("t1_brk", 32'(ev_break), 0);
        chk("t1_ext", 32'(ev_ext), 0);
        repeat (19) tick();
        chk("t1_held_count", 32'(count), 1);
        drain();

        // make / break / extended classification
        code_in = 16'h0000;
        tick();
        send(16'h001C, 1'b1);
        send(16'hF01C, 1'b1);
        send(16'hE075, 1'b1);
        send(16'hF075, 1'b1);
        chk("t2_count", 32'(count), FILTER ? 2 : 4);
        drain();

        // overflow on the 9th code
        for (int i = 1; i <= 9; i++) send(16'(i), i <= 8);
        chk("t3_count", 32'(count), 8);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_head", 32'(ev_code), 32'h0001);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 0);
        chk("t3_count_kept", 32'(count), 8);

        // full with simultaneous pop accepts the push
        ev_ready = 1'b1;
        send(16'h00AA, 1'b1);
        ev_ready = 1'b0;
        chk("t4_count", 32'(count), 8);
        chk("t4_ovf", 32'(overflow), 0);
        drain();

        // empty FIFO with ready held: single-cycle valid
        ev_ready = 1'b1;
        send(16'h0033, 1'b1);
        chk("t5_valid1", 32'(ev_valid), 1);
        chk("t5_count1", 32'(count), 1);
        tick();
        chk("t5_valid0", 32'(ev_valid), 0);
        chk("t5_count0", 32'(count), 0);
        ev_ready = 1'b0;

`ifdef PS2_BREAK_FILTER_EN
        send(16'h001C, 1'b1);
        send(16'hF01C, 1'b1);
        chk("filter_count", 32'(count), 1);
        drain();
`endif

        // asynchronous reset mid-operation
        for (int i = 1; i <= 5; i++) send(16'h0100 + 16'(i), 1'b1);
        chk("t6_count_pre", 32'(count), 5);
        #2;
        rst_n   = 1'b0;
        code_in = 16'h0000;
        #1;
        chk("t6_valid", 32'(ev_valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_ovf", 32'(overflow), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(16'hE042, 1'b1);
        chk("t6_post_count", 32'(count), 1);
        chk("t6_post_ext", 32'(ev_ext), 1);
        drain();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
